// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter that time-shares one 16-bit ripple-carry adder
// between N_REQ requesters, one grant/compute/response sequence at a time.
module full_adder_16b (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_sum,
   output logic        o_cout
);
   logic [16:0] w_c;
   assign w_c[0] = i_cin;
   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end
   assign o_cout = w_c[16];
endmodule

module add_share_arb #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [16*N_REQ-1:0]   req_a,
   input  logic [16*N_REQ-1:0]   req_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [15:0]           rsp_sum,
   output logic                  rsp_carry,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
   state_t            r_state, w_next;
   logic [15:0]       r_op_a, r_op_b, w_sum;
   logic [ID_W-1:0]   r_id, r_last, w_win, w_idx;
   logic              w_any, w_cout, w_grant;
   logic [15:0]       w_a [N_REQ];
   logic [15:0]       w_b [N_REQ];
   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      assign w_a[i] = req_a[16*i +: 16];
      assign w_b[i] = req_b[16*i +: 16];
   end
   // Scan downward in distance so the requester closest after r_last is the final assignment
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_idx = ID_W'((int'(r_last) + k) % N_REQ);
         if (req_valid[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
   end
   assign w_grant = (r_state == IDLE) && w_any;
   full_adder_16b u_add (
      .i_a    (r_op_a),
      .i_b    (r_op_b),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );
   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb
      w_next = (r_state == IDLE) ? (w_any ? CALC : IDLE) :
               (r_state == CALC) ? RESP :
               (rsp_ready ? IDLE : RESP);
   always_comb begin
      req_ready = (w_grant && !rst) ? (N_REQ'(1) << w_win) : '0;
      busy      = r_state != IDLE;
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_id      <= '0;
         r_last    <= ID_W'(N_REQ - 1);
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
      end else begin
         if (w_grant) begin
            r_op_a <= w_a[w_win];
            r_op_b <= w_b[w_win];
            r_id   <= w_win;
            r_last <= w_win;
         end
         if (r_state == CALC) begin
            rsp_sum   <= w_sum;
            rsp_carry <= w_cout;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
         end
         if (r_state == RESP && rsp_ready) rsp_valid <= 1'b0;
      end
endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb: directed checks plus a randomised scoreboard against a
// transaction-level model of the round-robin adder-sharing block.
module tb_add_share_arb;
   localparam int N = 4;
   localparam int IW = 2;
   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready;
   logic [16*N-1:0] req_a, req_b;
   logic            rsp_valid, rsp_ready, rsp_carry, busy;
   logic [IW-1:0]   rsp_id;
   logic [15:0]     rsp_sum;
   int n_assert = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   add_share_arb #(.N_REQ(N), .ID_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry),
      .busy      (busy)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      step;
      step;
      rst = 1'b0;
   endtask
   // One full transaction with rsp_ready high; entered and left in an IDLE cycle.
   task automatic txn(input int id, input logic [15:0] a, input logic [15:0] b,
                      input logic [N-1:0] v, input bit hold, input string tag);
      logic [16:0] e;
      e = 17'(a) + 17'(b);
      req_valid = v;
      req_a[16*id +: 16] = a;
      req_b[16*id +: 16] = b;
      rsp_ready = 1'b1;
      #1;
      chk({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
      step;
      if (!hold) req_valid = '0;
      #1;
      chk({tag, "_calc_busy"}, 32'(busy), 1);
      chk({tag, "_calc_ready"}, 32'(req_ready), 0);
      chk({tag, "_calc_vld"}, 32'(rsp_valid), 0);
      step;
      #1;
      chk({tag, "_rsp_vld"}, 32'(rsp_valid), 1);
      chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
      chk({tag, "_rsp_res"}, 32'({rsp_carry, rsp_sum}), 32'(e));
      step;
      #1;
      chk({tag, "_done_vld"}, 32'(rsp_valid), 0);
   endtask
   logic [N-1:0] pend, exp_rdy;
   logic [15:0]  pa [N];
   logic [15:0]  pb [N];
   int           wgt [N];
   int           m_ph, m_last, done, cyc, win;
   logic [IW-1:0] e_id;
   logic [16:0]  e_res;
   initial begin
      req_a = '0;
      req_b = '0;
      do_reset;
      #1;
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_sum", 32'(rsp_sum), 0);
      chk("rst_carry", 32'(rsp_carry), 0);
      chk("rst_ready", 32'(req_ready), 0);
      step;
      txn(0, 16'h1234, 16'h1111, 4'b0001, 0, "single");
      txn(2, 16'hFFFF, 16'h0001, 4'b0100, 0, "ovf1");
      txn(1, 16'hFFFF, 16'hFFFF, 4'b0010, 0, "ovf2");
      // continuous round robin: grants every 3 cycles in order 0,1,2,3,0,1
      do_reset;
      for (int i = 0; i < 6; i++)
         txn(i % N, 16'(16'h1000 * i + 16'h0101), 16'(16'h0F0F + i), 4'b1111, 1, "rr");
      do_reset;
      txn(1, 16'h0003, 16'h0004, 4'b1010, 1, "rr13a");
      txn(3, 16'h8000, 16'h8000, 4'b1010, 0, "rr13b");
      // backpressure in RESP
      req_valid = 4'b0100;
      req_a[32 +: 16] = 16'hFFFF;
      req_b[32 +: 16] = 16'h0001;
      rsp_ready = 1'b0;
      #1;
      chk("bp_grant", 32'(req_ready), 32'b0100);
      step;
      req_valid = 4'b1111;
      step;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_vld", 32'(rsp_valid), 1);
         chk("bp_id", 32'(rsp_id), 2);
         chk("bp_res", 32'({rsp_carry, rsp_sum}), 32'h10000);
         chk("bp_ready", 32'(req_ready), 0);
         step;
      end
      rsp_ready = 1'b1;
      step;
      #1;
      chk("bp_rel_vld", 32'(rsp_valid), 0);
      chk("bp_rel_grant", 32'(req_ready), 32'b1000);
      req_valid = '0;
      step;
      step;
      step;
      // reset during CALC after granting requester 0
      txn(0, 16'h0001, 16'h0001, 4'b0001, 0, "pre");
      req_valid = 4'b0001;
      #1;
      chk("rc_grant", 32'(req_ready), 1);
      step;
      req_valid = '0;
      rst = 1'b1;
      step;
      rst = 1'b0;
      #1;
      chk("rc_busy", 32'(busy), 0);
      for (int i = 0; i < 4; i++) begin
         chk("rc_novld", 32'(rsp_valid), 0);
         step;
      end
      txn(0, 16'h00AA, 16'h0055, 4'b0101, 0, "rc_next");
      // randomised scoreboard
      do_reset;
      pend = '0;
      m_ph = 0;
      m_last = N - 1;
      done = 0;
      cyc = 0;
      e_id = '0;
      e_res = '0;
      for (int i = 0; i < N; i++) wgt[i] = 0;
      while (done < 1000 && cyc < 20000) begin
         cyc++;
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               pa[i] = 16'($urandom);
               pb[i] = 16'($urandom);
               wgt[i] = 0;
            end
            req_a[16*i +: 16] = pend[i] ? pa[i] : 16'($urandom);
            req_b[16*i +: 16] = pend[i] ? pb[i] : 16'($urandom);
         end
         req_valid = pend;
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         exp_rdy = '0;
         win = -1;
         if (m_ph == 0)
            for (int k = 1; k <= N; k++)
               if (win < 0 && pend[(m_last + k) % N]) win = (m_last + k) % N;
         if (win >= 0) exp_rdy = N'(1 << win);
         chk("r_ready", 32'(req_ready), 32'(exp_rdy));
         chk("r_busy", 32'(busy), 32'(m_ph != 0));
         chk("r_vld", 32'(rsp_valid), 32'(m_ph == 2));
         if (m_ph == 2) begin
            chk("r_id", 32'(rsp_id), 32'(e_id));
            chk("r_res", 32'({rsp_carry, rsp_sum}), 32'(e_res));
         end
         if (win >= 0) begin
            chk("r_fair", 32'(wgt[win] <= N - 1), 1);
            for (int i = 0; i < N; i++) if (pend[i] && i != win) wgt[i]++;
            e_id = IW'(win);
            e_res = 17'(pa[win]) + 17'(pb[win]);
            pend[win] = 1'b0;
            m_last = win;
            m_ph = 1;
         end else if (m_ph == 1) m_ph = 2;
         else if (m_ph == 2 && rsp_ready) begin
            m_ph = 0;
            done++;
         end
         step;
      end
      chk("r_done", 32'(done), 1000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
